// File: rtl/apb_timer.sv
// apb_timer: APB completer with a 32-bit down-counting timer, 16-bit prescaler,
// periodic / one-shot modes, sticky timeout flag (W1C) and a level interrupt.
// Every access is stretched by WAIT_STATES cycles with PREADY low.
//
// Ports:
//   PCLK     in   single clock
//   PRESET   in   synchronous active-high reset
//   PSEL     in   completer select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   byte address, bits [1:0] ignored
//   PWDATA   in   write data
//   PRDATA   out  read data, registered, nonzero only in DONE
//   PREADY   out  registered transfer completion, high only in DONE
//   IRQ      out  TOF & CTRL.IRQEN
//
// Bus FSM:
//   state   | meaning
//   IDLE    | waiting for PSEL & PENABLE
//   WAIT    | inserting wait states, PREADY low
//   DONE    | PREADY high for one cycle, write commits here
//
// Register map: 0x00 CTRL {ONESHOT,IRQEN,EN}, 0x04 PRESCALE[15:0],
//               0x08 LOAD, 0x0C VALUE (RO), 0x10 STATUS {TOF} (W1C)

module apb_timer #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              IRQ
);

  localparam int AW = ADDR_W - 2;
  localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  wcnt;

  logic        en, irqen, oneshot, tof;
  logic [15:0] prescale, pcnt;
  logic [31:0] load, value;
  logic [31:0] rdata;

  logic [AW-1:0] word;
  logic sel_ctrl, sel_pre, sel_load, sel_val, sel_stat;
  logic wr_en, tick, tof_set;
  logic addr_lsb_unused;

  assign word     = PADDR[ADDR_W-1:2];
  assign sel_ctrl = (word == AW'(0));
  assign sel_pre  = (word == AW'(1));
  assign sel_load = (word == AW'(2));
  assign sel_val  = (word == AW'(3));
  assign sel_stat = (word == AW'(4));
  assign addr_lsb_unused = ^PADDR[1:0];

  // The bridge holds address/data stable through the access, so the
  // commit uses the values present in the DONE cycle.
  assign wr_en   = (state == ST_DONE) && PWRITE;
  assign tick    = en && (pcnt == prescale);
  assign tof_set = tick && (value == 32'd0);
  assign IRQ     = tof && irqen;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (PSEL && PENABLE) state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_DONE;
      ST_WAIT: begin
        if (!PSEL)              state_nxt = ST_IDLE;
        else if (wcnt == 3'd0)  state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'd0;
    if (sel_ctrl)      rdata = {29'd0, oneshot, irqen, en};
    else if (sel_pre)  rdata = {16'd0, prescale};
    else if (sel_load) rdata = load;
    else if (sel_val)  rdata = value;
    else if (sel_stat) rdata = {31'd0, tof};
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state  <= ST_IDLE;
      wcnt   <= 3'd0;
      PREADY <= 1'b0;
      PRDATA <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_WAIT)
        wcnt <= WCNT_INIT;
      else if (state == ST_WAIT && wcnt != 3'd0)
        wcnt <= wcnt - 3'd1;
      // DONE always returns to IDLE, so next==DONE marks entry into DONE
      PREADY <= (state_nxt == ST_DONE);
      PRDATA <= (state_nxt == ST_DONE) ? rdata : 32'd0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en       <= 1'b0;
      irqen    <= 1'b0;
      oneshot  <= 1'b0;
      prescale <= 16'd0;
      load     <= 32'd0;
      value    <= 32'd0;
      pcnt     <= 16'd0;
      tof      <= 1'b0;
    end else begin
      // A bus write to CTRL overrides the one-shot auto-disable.
      if (wr_en && sel_ctrl) begin
        en      <= PWDATA[0];
        irqen   <= PWDATA[1];
        oneshot <= PWDATA[2];
      end else if (tof_set && oneshot) begin
        en <= 1'b0;
      end

      if (wr_en && sel_pre)  prescale <= PWDATA[15:0];
      if (wr_en && sel_load) load     <= PWDATA;

      // pcnt sits at 0 while disabled, so an EN 0->1 write always starts
      // the prescaler from 0.
      if (!en || (wr_en && sel_load) || tick) pcnt <= 16'd0;
      else                                    pcnt <= pcnt + 16'd1;

      if (wr_en && sel_load) value <= PWDATA;
      else if (tick)         value <= (value == 32'd0) ? load : value - 32'd1;

      // Set beats a same-cycle W1C so no timeout is lost.
      if (tof_set)                            tof <= 1'b1;
      else if (wr_en && sel_stat && PWDATA[0]) tof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
module tb_apb_timer;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, psel0, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] prdata1, prdata0;
  logic        pready1, pready0, irq1, irq0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 PCLK = ~PCLK;

  apb_timer #(.ADDR_W(8), .WAIT_STATES(1)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata1), .PREADY(pready1), .IRQ(irq1)
  );

  apb_timer #(.ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata0), .PREADY(pready0), .IRQ(irq0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Called at a negedge. cyc counts negedges after the edge that first sees
  // PSEL&PENABLE, up to and including the one where PREADY is high.
  task automatic xfer(input bit sel0, input bit wr, input logic [7:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int cyc);
    if (sel0) psel0 = 1'b1; else PSEL = 1'b1;
    PWRITE = wr; PADDR = addr; PWDATA = wdata; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    cyc = 0;
    rdata = 'x;
    while (cyc < 20) begin
      @(negedge PCLK);
      cyc++;
      if ((sel0 ? pready0 : pready1) === 1'b1) begin
        rdata = sel0 ? prdata0 : prdata1;
        break;
      end
    end
    @(negedge PCLK);
    PSEL = 1'b0; psel0 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input bit sel0, input logic [7:0] addr, input logic [31:0] data, input string tag);
    logic [31:0] d;
    int c;
    xfer(sel0, 1'b1, addr, data, d, c);
    check({tag, "_wait"}, 32'(c), sel0 ? 32'd1 : 32'd2);
  endtask

  task automatic rd(input bit sel0, input logic [7:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    int c;
    xfer(sel0, 1'b0, addr, 32'd0, d, c);
    check({tag, "_wait"}, 32'(c), sel0 ? 32'd1 : 32'd2);
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; psel0 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 8'h00; PWDATA = 32'd0;
    repeat (3) @(negedge PCLK);
    check("rst_pready", {31'd0, pready1}, 32'd0);
    check("rst_prdata", prdata1, 32'd0);
    check("rst_irq",    {31'd0, irq1}, 32'd0);
    PRESET = 1'b0;

    rd(0, 8'h00, 32'd0, "rst_ctrl");
    rd(0, 8'h04, 32'd0, "rst_prescale");
    rd(0, 8'h08, 32'd0, "rst_load");
    rd(0, 8'h0C, 32'd0, "rst_value");
    rd(0, 8'h10, 32'd0, "rst_status");

    // Periodic, LOAD=3, PRESCALE=1: ticks every 2nd edge after the CTRL
    // commit edge P0 (P2,P4,...); VALUE 3,2,1,0 then TOF+reload at P8.
    wr(0, 8'h08, 32'd3, "wr_load");
    wr(0, 8'h04, 32'd1, "wr_prescale");
    wr(0, 8'h00, 32'h3, "wr_ctrl");
    rd(0, 8'h0C, 32'd2, "per_value_p3");        // sampled at P3
    check("per_irq_low", {31'd0, irq1}, 32'd0);
    rd(0, 8'h0C, 32'd0, "per_value_p7");        // sampled at P7
    check("per_irq_high", {31'd0, irq1}, 32'd1);
    rd(0, 8'h0C, 32'd2, "per_value_p11");       // reloaded 3 at P8, ticked at P10
    // W1C commits at P16, the same edge a tick at VALUE=0 sets TOF again.
    wr(0, 8'h10, 32'd1, "w1c_collide");
    check("collide_irq", {31'd0, irq1}, 32'd1);
    rd(0, 8'h10, 32'd1, "collide_tof");
    // CTRL=IRQEN only, committing at P24 (another TOF+reload edge).
    wr(0, 8'h00, 32'h2, "wr_ctrl_stop");
    check("stop_irq", {31'd0, irq1}, 32'd1);
    rd(0, 8'h0C, 32'd3, "stop_value_reload");
    wr(0, 8'h10, 32'd1, "w1c");
    check("w1c_irq", {31'd0, irq1}, 32'd0);
    rd(0, 8'h10, 32'd0, "w1c_tof");

    // One-shot, LOAD=2, PRESCALE=0: 3 ticks then EN drops, VALUE reloads.
    wr(0, 8'h08, 32'd2, "os_load");
    wr(0, 8'h04, 32'd0, "os_prescale");
    wr(0, 8'h00, 32'h7, "os_ctrl");
    repeat (4) @(negedge PCLK);
    check("os_irq", {31'd0, irq1}, 32'd1);
    rd(0, 8'h00, 32'h6, "os_ctrl_rb");
    rd(0, 8'h10, 32'd1, "os_tof");
    rd(0, 8'h0C, 32'd2, "os_value");
    wr(0, 8'h10, 32'd1, "os_w1c");
    check("os_w1c_irq", {31'd0, irq1}, 32'd0);

    // Unmapped offset and reserved CTRL bits.
    wr(0, 8'h14, 32'hFFFF_FFFF, "wr_unmapped");
    rd(0, 8'h14, 32'd0, "rd_unmapped");
    rd(0, 8'h08, 32'd2, "unmapped_load");
    rd(0, 8'h00, 32'h6, "unmapped_ctrl");
    wr(0, 8'h00, 32'hFFFF_FFF6, "wr_ctrl_rsvd");
    rd(0, 8'h00, 32'h6, "ctrl_rsvd");

    // Reset while the LOAD write sits in WAIT.
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'h55; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_wait_pready", {31'd0, pready1}, 32'd0);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("abort_pready", {31'd0, pready1}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PRESET = 1'b0;
    rd(0, 8'h08, 32'd0, "abort_load");
    rd(0, 8'h00, 32'd0, "abort_ctrl");

    // Zero-wait instance: PREADY on the first access cycle.
    wr(1, 8'h08, 32'h55, "zw_wr_load");
    rd(1, 8'h08, 32'h55, "zw_load");
    rd(1, 8'h0C, 32'h55, "zw_value");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
